trigger_unit: RTL
=================

# trigger_unit

Parametrised trigger engine for the triggerer tile: watches a sampled data stream, detects a programmable trigger condition (level, rising/falling threshold crossing, or masked pattern match), and emits a delayed, width-programmable trigger pulse. A holdoff window follows each pulse, and the unit re-arms automatically while `arm` is held. It sits between the tile's input pins (sample source) and the output pins (trigger pulse and status), replacing the fixed combinational datapath with a configurable sequential one.

## Interface
- `WIDTH`, 8, sample / threshold / mask width (≥2)
- `CNT_W`, 8, width of delay, pulse-length, holdoff and trigger-count fields (≥2)

- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `din`  in  WIDTH  sample, unsigned
- `din_valid`  in  1  `din` valid this cycle
- `level`  in  WIDTH  threshold (modes 0–2) or pattern (mode 3)
- `mask`  in  WIDTH  pattern mask, mode 3 only
- `mode`  in  2  0 = level (din ≥ level), 1 = rising crossing, 2 = falling crossing, 3 = masked pattern
- `arm`  in  1  level-sensitive arm / re-arm enable
- `delay`  in  CNT_W  cycles from qualifying sample to pulse start
- `pulse_len`  in  CNT_W  pulse width in cycles (0 treated as 1)
- `holdoff`  in  CNT_W  dead cycles after pulse (0 = none)
- `armed`  out  1  state is ARMED
- `busy`  out  1  state is DELAY, PULSE or HOLDOFF
- `trig_out`  out  1  trigger pulse, registered
- `trig_count`  out  CNT_W  saturating count of pulses issued

## Operation
- Reset: one clock cycle with `rst`=1 forces IDLE. All outputs are 0 from the next cycle, including `trig_count`. Reset asserted in any state aborts the current operation. No partial pulse is emitted after reset.
- Previous-sample register `prev` and flag `prev_ok` are updated on every `din_valid` cycle in every state. `prev_ok` is cleared while in IDLE. Cycles with `din_valid`=0 are ignored and leave `prev` unchanged.
- Condition `hit` (requires `din_valid`):
  - mode 0: din ≥ level
  - mode 1: prev_ok && prev < level && din ≥ level
  - mode 2: prev_ok && prev ≥ level && din < level
  - mode 3: (din & mask) == (level & mask)
  - All comparisons are unsigned.
- FSM states: IDLE, ARMED, DELAY, PULSE, HOLDOFF.
  - IDLE: `arm`=1 → ARMED.
  - ARMED: `arm`=0 → IDLE, with priority over `hit`. On `hit`, latch `delay`, `pulse_len` and `holdoff`, then go to DELAY (delay>0) or PULSE (delay=0). `mode`, `level` and `mask` are used live.
  - DELAY: counts latched delay cycles (clock cycles, not samples), then → PULSE.
  - PULSE: `trig_out`=1 for max(pulse_len,1) cycles. `trig_count` increments on entry and saturates at all-ones. Exit → HOLDOFF (holdoff>0), else → ARMED if `arm`=1, else → IDLE.
  - HOLDOFF: latched holdoff cycles, then → ARMED if `arm`=1, else → IDLE.
- Deasserting `arm` during DELAY, PULSE or HOLDOFF does not abort; the sequence completes, then the unit goes to IDLE.
- Config input changes after the latch point do not affect the sequence in flight.

## Timing
- Qualifying sample in cycle T: `trig_out` high in cycles T+1+delay through T+delay+max(pulse_len,1).
- Latency from `arm` rising (cycle A) to `armed`=1 is cycle A+1. The first sample usable for detection is in cycle A+1.
- Crossing modes: the first valid sample after leaving IDLE only loads `prev` and can never trigger.
- Re-trigger period with `arm` held and a continuously true condition: 1 + delay + max(pulse_len,1) + holdoff + 1 cycles.
- `armed`, `busy` and `trig_out` are registered state decodes, so they are glitch-free and mutually consistent every cycle.

## Test plan
- Reset: hold `rst` 2 cycles mid-stream → `armed`=`busy`=`trig_out`=0, `trig_count`=0. The first cycle after release is still IDLE.
- Rising crossing: mode=1, level=0x80, delay=0, pulse_len=3, `arm`=1; samples 0x70 then 0x90 at cycle T → `trig_out`=1 in T+1..T+3, `trig_count`=1. A following 0xA0 sample (no crossing) gives no pulse.
- Delay and falling crossing: mode=2, level=0x40, delay=5, pulse_len=0; samples 0x50, 0x30 at T → `trig_out` high only in T+6, and `busy` high T+1..T+6.
- Pattern: mode=3, mask=0xF0, level=0xA0 → din=0xB0 gives no trigger; din=0xA7 triggers. Changing `level` during DELAY does not alter the pulse.
- Holdoff re-arm: mode=0, level=0x10, din=0xFF every cycle, delay=0, pulse_len=1, holdoff=4, `arm` held → pulses every 7 cycles. With CNT_W=2, `trig_count` saturates at 3.
- Abort cases:
  - First sample after arm equals 0x90 in mode 1 → no trigger.
  - `rst` pulsed during DELAY → no pulse, IDLE.
  - `arm` dropped in ARMED → IDLE next cycle.
  - `arm` dropped in PULSE → pulse completes, then IDLE.

Source files
------------

// File: rtl/trigger_unit.sv
// Configurable trigger engine: detects level / crossing / pattern conditions on a
// sampled stream and emits a delayed, width-programmable pulse followed by holdoff.
module trigger_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] level,
    input  logic [WIDTH-1:0] mask,
    input  logic [1:0]       mode,
    input  logic             arm,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] pulse_len,
    input  logic [CNT_W-1:0] holdoff,
    output logic             armed,
    output logic             busy,
    output logic             trig_out,
    output logic [CNT_W-1:0] trig_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_PULSE,
        S_HOLDOFF
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] pl_lat;
    logic [CNT_W-1:0] ho_lat;
    logic [CNT_W-1:0] pl_eff;
    logic [WIDTH-1:0] prev;
    logic             prev_ok;
    logic             rearm_wait;
    logic             hit;
    logic             latch_cfg;
    logic             pulse_entry;

    assign pl_eff      = (pulse_len == '0) ? CNT_ONE : pulse_len;
    assign pulse_entry = (state_nxt == S_PULSE) && (state != S_PULSE);

    // Trigger condition; all comparisons unsigned, crossing modes need a valid prior sample.
    always_comb begin
        hit = 1'b0;
        if (din_valid) begin
            case (mode)
                2'd0:    hit = (din >= level);
                2'd1:    hit = prev_ok && (prev < level) && (din >= level);
                2'd2:    hit = prev_ok && (prev >= level) && (din < level);
                default: hit = ((din & mask) == (level & mask));
            endcase
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_nxt = state;
        cnt_nxt   = cnt;
        latch_cfg = 1'b0;
        case (state)
            S_IDLE: begin
                if (arm) state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (!arm) begin
                    state_nxt = S_IDLE;
                end else if (hit && !rearm_wait) begin
                    latch_cfg = 1'b1;
                    if (delay != '0) begin
                        state_nxt = S_DELAY;
                        cnt_nxt   = delay - CNT_ONE;
                    end else begin
                        state_nxt = S_PULSE;
                        cnt_nxt   = pl_eff - CNT_ONE;
                    end
                end
            end
            S_DELAY: begin
                if (cnt == '0) begin
                    state_nxt = S_PULSE;
                    cnt_nxt   = pl_lat - CNT_ONE;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            S_PULSE: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_ONE;
                end else if (ho_lat != '0) begin
                    state_nxt = S_HOLDOFF;
                    cnt_nxt   = ho_lat - CNT_ONE;
                end else begin
                    state_nxt = arm ? S_ARMED : S_IDLE;
                end
            end
            S_HOLDOFF: begin
                if (cnt != '0) cnt_nxt = cnt - CNT_ONE;
                else           state_nxt = arm ? S_ARMED : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            pl_lat     <= '0;
            ho_lat     <= '0;
            prev       <= '0;
            prev_ok    <= 1'b0;
            rearm_wait <= 1'b0;
            armed      <= 1'b0;
            busy       <= 1'b0;
            trig_out   <= 1'b0;
            trig_count <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (latch_cfg) begin
                pl_lat <= pl_eff;
                ho_lat <= holdoff;
            end
            if (din_valid) prev <= din;
            if (state == S_IDLE)  prev_ok <= 1'b0;
            else if (din_valid)   prev_ok <= 1'b1;
            // One dead ARMED cycle after a completed sequence sets the re-trigger period.
            rearm_wait <= (state_nxt == S_ARMED) &&
                          ((state == S_PULSE) || (state == S_HOLDOFF));
            armed    <= (state_nxt == S_ARMED);
            busy     <= (state_nxt == S_DELAY) || (state_nxt == S_PULSE) ||
                        (state_nxt == S_HOLDOFF);
            trig_out <= (state_nxt == S_PULSE);
            if (pulse_entry && (trig_count != CNT_MAX)) trig_count <= trig_count + CNT_ONE;
        end
    end

endmodule
